pipe_load: RTL and testbench

PIPE_LOAD -- requirements
Module: pipe_load

---
 rtl/pipe_load.sv | 99 +++++++++
 tb/tb_pipe_load.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_load.sv
// Two-stage load pipeline: S1 resolves the address from a forwarded base register,
// S2 reads memory, and the output stage writes back into a 16x16 register bank.
module pipe_load (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  rs1,
    input  logic [7:0]  offset,
    input  logic [3:0]  rd,
    input  logic        mem_we,
    input  logic [7:0]  mem_waddr,
    input  logic [15:0] mem_wdata,
    input  logic        rf_we,
    input  logic [3:0]  rf_waddr,
    input  logic [15:0] rf_wdata,
    output logic        out_valid,
    output logic [3:0]  out_rd,
    output logic [15:0] Zout
);

    logic [15:0] reg_bank [16];
    logic [15:0] mem [256];

    logic        s1_valid;
    logic [3:0]  s1_rd;
    logic [7:0]  s1_addr;
    logic        s2_valid;
    logic [3:0]  s2_rd;
    logic [15:0] s2_data;

    logic [15:0] base;
    logic [7:0]  load_addr;
    logic        accept;
    logic        unused_base_hi;

    // Only S2 needs a bypass: by the time a load leaves S2 it is already in the bank.
    always_comb begin
        in_ready       = !(s1_valid && (s1_rd == rs1));
        base           = (s2_valid && (s2_rd == rs1)) ? s2_data : reg_bank[rs1];
        accept         = in_valid && in_ready;
        load_addr      = base[7:0] + offset;
        unused_base_hi = ^base[15:8];
    end

    // NOTE: memory has no reset so it maps onto RAM and survives rst_n; the
    // non-blocking write also means a same-edge read in S2 sees the old word.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            s1_rd     <= '0;
            s1_addr   <= '0;
            s2_valid  <= 1'b0;
            s2_rd     <= '0;
            s2_data   <= '0;
            out_valid <= 1'b0;
            out_rd    <= '0;
            Zout      <= '0;
        end else begin
            s1_valid <= accept;
            if (accept) begin
                s1_rd   <= rd;
                s1_addr <= load_addr;
            end
            s2_valid  <= s1_valid;
            s2_rd     <= s1_rd;
            s2_data   <= mem[s1_addr];
            out_valid <= s2_valid;
            if (s2_valid) begin
                out_rd <= s2_rd;
                Zout   <= s2_data;
            end
        end
    end

    // NOTE: with non-blocking assignments the last write to an element in the
    // block wins, so the writeback below takes priority over rf_we on a clash.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) begin
                reg_bank[i] <= '0;
            end
        end else begin
            if (rf_we) begin
                reg_bank[rf_waddr] <= rf_wdata;
            end
            if (s2_valid) begin
                reg_bank[s2_rd] <= s2_data;
            end
        end
    end

endmodule

// File: tb/tb_pipe_load.sv
// Directed bench for pipe_load: stimulus pushes expected {rd, data} into a
// scoreboard queue, and a negedge monitor pops and compares on each out_valid.
module tb_pipe_load;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  rs1;
    logic [7:0]  offset;
    logic [3:0]  rd;
    logic        mem_we;
    logic [7:0]  mem_waddr;
    logic [15:0] mem_wdata;
    logic        rf_we;
    logic [3:0]  rf_waddr;
    logic [15:0] rf_wdata;
    logic        out_valid;
    logic [3:0]  out_rd;
    logic [15:0] Zout;

    int vectors = 0;
    int miscompares = 0;
    int run_len = 0;
    int max_run = 0;
    logic [19:0] scb [$];

    pipe_load dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .rs1       (rs1),
        .offset    (offset),
        .rd        (rd),
        .mem_we    (mem_we),
        .mem_waddr (mem_waddr),
        .mem_wdata (mem_wdata),
        .rf_we     (rf_we),
        .rf_waddr  (rf_waddr),
        .rf_wdata  (rf_wdata),
        .out_valid (out_valid),
        .out_rd    (out_rd),
        .Zout      (Zout)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every completed load must match the oldest expected entry.
    always @(negedge clk) begin
        if (out_valid === 1'b1) begin
            run_len++;
            if (run_len > max_run) max_run = run_len;
            if (scb.size() == 0) begin
                check("unexpected_out_valid", 32'd1, 32'd0);
            end else begin
                logic [19:0] exp;
                exp = scb.pop_front();
                check("out_rd", {28'd0, out_rd}, {28'd0, exp[19:16]});
                check("Zout", {16'd0, Zout}, {16'd0, exp[15:0]});
            end
        end else begin
            run_len = 0;
        end
    end

    // All tasks below are entered and left at posedge+1.
    task automatic mem_write(input logic [7:0] a, input logic [15:0] d);
        mem_we = 1'b1; mem_waddr = a; mem_wdata = d;
        @(posedge clk); #1;
        mem_we = 1'b0;
    endtask

    task automatic rf_write(input logic [3:0] a, input logic [15:0] d);
        rf_we = 1'b1; rf_waddr = a; rf_wdata = d;
        @(posedge clk); #1;
        rf_we = 1'b0;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Leaves in_valid high so consecutive calls issue back to back.
    task automatic issue(input logic [3:0] r1, input logic [7:0] off, input logic [3:0] rdi,
                         input logic [15:0] exp, input bit push, output int stalls);
        in_valid = 1'b1; rs1 = r1; offset = off; rd = rdi;
        stalls = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (in_ready === 1'b1) begin
                if (push) scb.push_back({rdi, exp});
                @(posedge clk); #1;
                return;
            end
            stalls++;
        end
        check("issue_timeout", 32'd1, 32'd0);
    endtask

    task automatic check_regs_zero(input string tag);
        for (int i = 0; i < 16; i++) begin
            check($sformatf("%s_r%0d", tag, i), {16'd0, dut.reg_bank[i]}, 32'd0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int st;
        int total;
        rst_n = 1'b0; in_valid = 1'b0; rs1 = '0; offset = '0; rd = '0;
        mem_we = 1'b0; mem_waddr = '0; mem_wdata = '0;
        rf_we = 1'b0; rf_waddr = '0; rf_wdata = '0;

        // Reset, with the memory preload port exercised while held.
        @(posedge clk); #1;
        mem_write(8'h13, 16'hBEEF);
        mem_write(8'h10, 16'h1234);
        @(negedge clk);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_zout", {16'd0, Zout}, 32'd0);
        check("rst_out_rd", {28'd0, out_rd}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        check_regs_zero("rst");

        // Basic load with latency and writeback timing.
        rf_write(4'd2, 16'h0010);
        issue(4'd2, 8'h03, 4'd5, 16'hBEEF, 1'b1, st);
        in_valid = 1'b0;
        @(negedge clk); @(negedge clk);
        check("basic_lat_n1_valid", {31'd0, out_valid}, 32'd0);
        check("basic_r5_before", {16'd0, dut.reg_bank[5]}, 32'd0);
        @(negedge clk);
        check("basic_lat_n2_valid", {31'd0, out_valid}, 32'd1);
        check("basic_r5", {16'd0, dut.reg_bank[5]}, 32'h0000BEEF);
        @(posedge clk); #1;

        // Address wrap, including ignored upper base bits; rs1 == rd uses old base.
        rf_write(4'd1, 16'h00F0);
        rf_write(4'd3, 16'hFF05);
        rf_write(4'd11, 16'h0060);
        mem_write(8'h61, 16'h7777);
        issue(4'd1, 8'h20, 4'd6, 16'h1234, 1'b1, st);
        issue(4'd3, 8'h0B, 4'd8, 16'h1234, 1'b1, st);
        issue(4'd11, 8'h01, 4'd11, 16'h7777, 1'b1, st);
        idle(5);
        check("self_r11", {16'd0, dut.reg_bank[11]}, 32'h00007777);

        // Load-use hazard: exactly one bubble, base forwarded from S2.
        mem_write(8'h40, 16'h0050);
        mem_write(8'h58, 16'hCAFE);
        rf_write(4'd9, 16'h0040);
        issue(4'd9, 8'h00, 4'd4, 16'h0050, 1'b1, st);
        check("hazard_first_stalls", st, 32'd0);
        issue(4'd4, 8'h08, 4'd10, 16'hCAFE, 1'b1, st);
        check("hazard_stalls", st, 32'd1);
        idle(5);

        // Same-edge memory write at S2 capture and rf_we clash at writeback.
        mem_write(8'h70, 16'h1111);
        rf_write(4'd12, 16'h0070);
        issue(4'd12, 8'h00, 4'd7, 16'h1111, 1'b1, st);
        in_valid = 1'b0;
        mem_we = 1'b1; mem_waddr = 8'h70; mem_wdata = 16'h2222;
        @(posedge clk); #1;
        mem_we = 1'b0;
        rf_we = 1'b1; rf_waddr = 4'd7; rf_wdata = 16'hDEAD;
        @(posedge clk); #1;
        rf_we = 1'b0;
        idle(3);
        check("collide_r7", {16'd0, dut.reg_bank[7]}, 32'h00001111);
        issue(4'd12, 8'h00, 4'd13, 16'h2222, 1'b1, st);
        idle(5);

        // Reset with two loads in flight: both discarded, memory kept.
        issue(4'd0, 8'h13, 4'd14, 16'hBEEF, 1'b0, st);
        issue(4'd0, 8'h10, 4'd15, 16'h1234, 1'b0, st);
        in_valid = 1'b0;
        rst_n = 1'b0;
        mem_write(8'h90, 16'h9999);
        @(posedge clk); #1;
        rst_n = 1'b1;
        rs1 = 4'd5;
        @(negedge clk);
        check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("post_rst_out_valid", {31'd0, out_valid}, 32'd0);
        @(posedge clk); #1;
        idle(3);
        check_regs_zero("midrst");
        issue(4'd0, 8'h13, 4'd1, 16'hBEEF, 1'b1, st);
        issue(4'd0, 8'h90, 4'd2, 16'h9999, 1'b1, st);
        idle(5);

        // Throughput: eight independent loads, no stalls, one result per cycle.
        for (int i = 0; i < 8; i++) begin
            mem_write(8'h20 + 8'(i), 16'hA000 + 16'(i));
        end
        max_run = 0;
        total = 0;
        for (int i = 0; i < 8; i++) begin
            issue(4'd0, 8'h20 + 8'(i), 4'(i + 1), 16'hA000 + 16'(i), 1'b1, st);
            total += st;
        end
        idle(6);
        check("thru_stalls", total, 32'd0);
        check("thru_run", max_run, 32'd8);

        check("scoreboard_empty", scb.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
